serial_divider: RTL

SERIAL_DIVIDER -- requirements
Module: serial_divider

---
 rtl/serial_divider_pkg.sv | 15 +
 rtl/serial_divider_div_step.sv | 38 +++
 rtl/serial_divider.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/serial_divider_pkg.sv
// serial_divider_pkg
// Shared definitions for the serial restoring divider: the controller state
// encoding and the default operand widths.
package serial_divider_pkg;

  localparam int DVD_W_DEF = 16;
  localparam int DVS_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_divider_div_step.sv
// div_step
// One combinational restoring-division step.
// Ports:
//   rem_in   : partial remainder from the previous step (always < divisor)
//   bit_in   : next dividend bit, MSB first
//   divisor  : denominator
//   rem_out  : partial remainder after this step
//   qbit     : quotient bit produced by this step
module div_step
  import serial_divider_pkg::*;
#(
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic [DVS_W-1:0] rem_in,
  input  logic             bit_in,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVS_W-1:0] rem_out,
  output logic             qbit
);

  // The shifted partial remainder needs one extra bit: rem_in can be as large
  // as divisor-1, so {rem_in, bit} can exceed the DVS_W-bit range.
  logic [DVS_W:0] p;
  logic [DVS_W:0] diff;

  always_comb begin
    p    = {rem_in, bit_in};
    diff = p - {1'b0, divisor};
    if (p >= {1'b0, divisor}) begin
      qbit    = 1'b1;
      rem_out = diff[DVS_W-1:0];
    end else begin
      qbit    = 1'b0;
      rem_out = p[DVS_W-1:0];
    end
  end

endmodule

// File: rtl/serial_divider.sv
// serial_divider
// Multi-cycle restoring divider, one quotient bit per clock, MSB first.
// Ports:
//   clk         : clock, all state changes on the rising edge
//   rst         : synchronous active-low reset
//   start       : request a division (sampled only in IDLE)
//   dividend    : numerator, captured on the accepting edge
//   divisor     : denominator, captured on the accepting edge
//   busy        : high while iterating
//   done        : one-cycle pulse when quotient/remainder are fresh
//   quotient    : registered quotient
//   remainder   : registered remainder
//   div_by_zero : last result came from a zero divisor
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one restoring step per edge, DVD_W edges total
// DONE  | results valid, done pulse, back to IDLE next edge
module serial_divider
  import serial_divider_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(DVD_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DVD_W - 1);

  state_t           state_q, state_d;
  // Dividend bits shift out the top while quotient bits shift in the bottom.
  logic [DVD_W-1:0] dvd_q, dvd_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DVD_W-1:0] quo_out_q, quo_out_d;
  logic [DVS_W-1:0] rem_out_q, rem_out_d;
  logic             dbz_q, dbz_d;

  logic [DVS_W-1:0] step_rem;
  logic             step_qbit;
  logic [DVD_W-1:0] dvd_shift;

  div_step #(
    .DVS_W (DVS_W)
  ) u_div_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[DVD_W-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .qbit    (step_qbit)
  );

  assign dvd_shift = {dvd_q[DVD_W-2:0], step_qbit};

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dbz_d     = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            dvd_d   = dividend;
            dvs_d   = divisor;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            quo_out_d = '1;
            rem_out_d = dividend[DVS_W-1:0];
            dbz_d     = 1'b1;
            state_d   = DONE;
          end
        end
      end
      RUN: begin
        dvd_d = dvd_shift;
        rem_d = step_rem;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          quo_out_d = dvd_shift;
          rem_out_d = step_rem;
          dbz_d     = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quo_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_q;

endmodule
